diff_freq_serial_in: RTL and testbench
======================================

DIFF_FREQ_SERIAL_IN -- requirements
Module: diff_freq_serial_in

Interface
REQ-001 The block SHALL have parameter DATA_BIT, default 16, meaning the number of bits per frame (legal range 1..32).
REQ-002 The block SHALL have parameter LOW_FREQ, 8-bit, default 20, meaning clocks per bit when i_sel_freq=0.
REQ-003 The block SHALL have parameter HIGH_FREQ, 8-bit, default 10, meaning clocks per bit when i_sel_freq=1.
REQ-004 The block SHALL have parameter START_DELAY, default 2, meaning clocks from the accepted i_start to the first edge of the bit-0 window (the line-plus-synchronizer latency).
REQ-005 The block SHALL have port clk, input, 1 bit: the clock.
REQ-006 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous, active-low.
REQ-007 The block SHALL have port i_serial, input, 1 bit: the asynchronous serial line, LSB first.
REQ-008 The block SHALL have port i_start, input, 1 bit: begin frame reception.
REQ-009 The block SHALL have port i_stop, input, 1 bit: abort the frame.
REQ-010 The block SHALL have port i_sel_freq, input, 1 bit: period select for the bit window being opened.
REQ-011 The block SHALL have port o_data, output, DATA_BIT bits: the last completed frame.
REQ-012 The block SHALL have port o_done_tick, output, 1 bit: one-clock frame-complete strobe.
REQ-013 The block SHALL have port o_err, output, 1 bit: sample-disagreement flag for the last frame.
REQ-014 The block SHALL have port o_busy, output, 1 bit: high whenever the state is not S_IDLE.

Function
REQ-015 i_serial SHALL pass through a 2-flop synchronizer; all sampling SHALL use the synchronized value.
REQ-016 The FSM SHALL have states S_IDLE, S_WAIT, S_RECV and S_DONE.
REQ-017 In S_IDLE with i_start=1 and i_stop=0, the FSM SHALL go to S_WAIT, clear the shift register, the bit counter and the error accumulator, and load the delay counter.
REQ-018 S_WAIT SHALL last exactly START_DELAY clocks, then enter S_RECV and open bit window 0.
REQ-019 Opening a bit window SHALL sample i_sel_freq and set P=HIGH_FREQ if it is 1, otherwise LOW_FREQ; the cycle counter SHALL reset to 0.
REQ-020 Within a window the cycle counter SHALL run 0..P-1, and the window SHALL end at count P-1.
REQ-021 The line SHALL be sampled at counts P>>2, P>>1 and (P>>1)+(P>>2); the received bit SHALL be the majority of the three samples.
REQ-022 If the three samples are not all equal, the error accumulator SHALL be set and SHALL remain set for the rest of the frame.
REQ-023 At window end the received bit SHALL enter the shift register MSB side, shifting right, so bit 0 lands in o_data[0] after DATA_BIT windows.
REQ-024 After window DATA_BIT-1 the FSM SHALL enter S_DONE; otherwise the next window SHALL open on the following clock with no gap.
REQ-025 S_DONE SHALL last one clock; in that clock o_done_tick=1, o_data SHALL equal the shift register, o_err SHALL equal the accumulator, and the next state SHALL be S_IDLE.
REQ-026 o_data and o_err SHALL hold their values until the next S_DONE.
REQ-027 o_done_tick SHALL be registered and high for exactly one clock per completed frame.
REQ-028 i_stop=1 in any state other than S_IDLE SHALL force S_IDLE on the next clock with no o_done_tick, leaving o_data and o_err unchanged.
REQ-029 i_stop SHALL take priority over i_start; in S_IDLE, i_start and i_stop both high SHALL leave the FSM in S_IDLE.
REQ-030 i_start SHALL be ignored while o_busy=1.
REQ-031 LOW_FREQ and HIGH_FREQ below 4 are illegal; elaboration SHALL fail.
REQ-032 Frame length in clocks SHALL equal START_DELAY + sum of per-window P + 1.

Reset
REQ-033 rst_n low SHALL asynchronously force S_IDLE, o_data=0, o_done_tick=0, o_err=0, o_busy=0, all counters to 0 and the synchronizer flops to 0.
REQ-034 Reset asserted mid-frame SHALL discard the partial frame; after release the block SHALL wait in S_IDLE for i_start.

Structure
REQ-035 Package diff_freq_pkg SHALL hold the state encodings and the default LOW_FREQ and HIGH_FREQ constants, shared with the transmitter.
REQ-036 Sub-module bit_sync SHALL implement the 2-flop synchronizer; the sampling logic and the FSM SHALL stay in the top module.

Verification
REQ-037 Loopback: transmitter drives 16'hA5C3 with i_sel_freq=0 throughout; receiver started on the same clock -> o_data=16'hA5C3, o_err=0, tick at clock 2+320+1.
REQ-038 Mixed rates: i_sel_freq alternates 1/0 per bit, data 16'h0001 -> o_data=16'h0001, window lengths 10/20 alternating.
REQ-039 Glitch: invert the line for 1 clock at count P>>2 of bit 5 -> o_data is still correct and o_err=1.
REQ-040 Abort: i_stop at bit 7 -> no tick, o_data keeps the previous frame, o_busy=0 the next clock; a new i_start is accepted.
REQ-041 Start while busy: second i_start mid-frame is ignored -> exactly one tick; i_start and i_stop together in S_IDLE -> stays idle.
REQ-042 Reset mid-frame at bit 9 -> all outputs 0, no tick; a subsequent 16'hFFFF frame is received correctly.

Source files
------------

// File: rtl/diff_freq_pkg.sv
// Shared definitions for the dual-rate serial link: FSM encodings and the
// default bit periods used by both the transmitter and the receiver.
package diff_freq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RECV = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [7:0] DEF_LOW_FREQ  = 8'd20;
    localparam logic [7:0] DEF_HIGH_FREQ = 8'd10;

endpackage

// File: rtl/diff_freq_serial_in_bit_sync.sv
// Two-flop synchronizer bringing the asynchronous serial line into clk.
module bit_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/diff_freq_serial_in.sv
// Serial frame receiver with a per-bit selectable period; each bit is the
// majority of three samples taken inside its window, LSB first.
module diff_freq_serial_in
    import diff_freq_pkg::*;
#(
    parameter int         DATA_BIT    = 16,
    parameter logic [7:0] LOW_FREQ    = DEF_LOW_FREQ,
    parameter logic [7:0] HIGH_FREQ   = DEF_HIGH_FREQ,
    parameter int         START_DELAY = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_serial,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic                i_sel_freq,
    output logic [DATA_BIT-1:0] o_data,
    output logic                o_done_tick,
    output logic                o_err,
    output logic                o_busy,
    output logic [1:0]          o_state
);

    if (LOW_FREQ < 8'd4 || HIGH_FREQ < 8'd4) begin : g_bad_freq
        $error("diff_freq_serial_in: LOW_FREQ and HIGH_FREQ must be at least 4");
    end
    if (DATA_BIT < 1 || DATA_BIT > 32) begin : g_bad_width
        $error("diff_freq_serial_in: DATA_BIT must be within 1..32");
    end
    if (START_DELAY < 1 || START_DELAY > 256) begin : g_bad_delay
        $error("diff_freq_serial_in: START_DELAY must be within 1..256");
    end

    localparam logic [5:0] LAST_BIT = 6'(DATA_BIT - 1);
    localparam logic [7:0] DLY_LOAD = 8'(START_DELAY - 1);

    state_t              state;
    logic                line;
    logic [DATA_BIT-1:0] shreg;
    logic [5:0]          bit_cnt;
    logic [7:0]          dly_cnt;
    logic [7:0]          cnt;
    logic [7:0]          period;
    logic                err_acc;
    logic                s_a, s_b, s_c;

    bit_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (i_serial),
        .q     (line)
    );

    logic [7:0]          sel_p;
    logic [7:0]          pos_a, pos_b, pos_c;
    logic                c_eff;
    logic                maj;
    logic                next_err;
    logic [DATA_BIT-1:0] next_shreg;

    assign sel_p = i_sel_freq ? HIGH_FREQ : LOW_FREQ;
    assign pos_a = period >> 2;
    assign pos_b = period >> 1;
    assign pos_c = pos_a + pos_b;
    // For the shortest legal period the last sample lands on the window-end
    // count itself, so take it straight from the line in that case.
    assign c_eff      = (cnt == pos_c) ? line : s_c;
    assign maj        = (s_a & s_b) | (s_a & c_eff) | (s_b & c_eff);
    assign next_err   = err_acc | ~((s_a == s_b) && (s_b == c_eff));
    assign next_shreg = (shreg >> 1) | (DATA_BIT'(maj) << (DATA_BIT - 1));

    assign o_busy  = (state != S_IDLE);
    assign o_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            o_data      <= '0;
            o_err       <= 1'b0;
            o_done_tick <= 1'b0;
            shreg       <= '0;
            bit_cnt     <= '0;
            dly_cnt     <= '0;
            cnt         <= '0;
            period      <= '0;
            err_acc     <= 1'b0;
            s_a         <= 1'b0;
            s_b         <= 1'b0;
            s_c         <= 1'b0;
        end else begin
            o_done_tick <= 1'b0;
            if (state != S_IDLE && i_stop) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (i_start && !i_stop) begin
                            state   <= S_WAIT;
                            shreg   <= '0;
                            bit_cnt <= '0;
                            err_acc <= 1'b0;
                            dly_cnt <= DLY_LOAD;
                        end
                    end
                    S_WAIT: begin
                        if (dly_cnt == 8'd0) begin
                            state  <= S_RECV;
                            cnt    <= '0;
                            period <= sel_p;
                        end else begin
                            dly_cnt <= dly_cnt - 8'd1;
                        end
                    end
                    S_RECV: begin
                        if (cnt == pos_a) s_a <= line;
                        if (cnt == pos_b) s_b <= line;
                        if (cnt == pos_c) s_c <= line;
                        if (cnt == period - 8'd1) begin
                            shreg   <= next_shreg;
                            err_acc <= next_err;
                            cnt     <= '0;
                            if (bit_cnt == LAST_BIT) begin
                                state       <= S_DONE;
                                o_data      <= next_shreg;
                                o_err       <= next_err;
                                o_done_tick <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                                period  <= sel_p;
                            end
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_diff_freq_serial_in.sv
// Bench for diff_freq_serial_in: a behavioural transmitter plus a window-level
// reference model of the sampled bits, error flag and frame timing.
module tb_diff_freq_serial_in;

    localparam int LOW  = 20;
    localparam int HIGH = 10;
    localparam int SD   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_serial = 1'b1;
    logic        i_start = 1'b0;
    logic        i_stop = 1'b0;
    logic        i_sel_freq = 1'b0;
    logic [15:0] o_data;
    logic        o_done_tick;
    logic        o_err;
    logic        o_busy;
    logic [1:0]  o_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] prev_data = '0;
    logic        prev_err  = 1'b0;
    logic [16:0] exp_q[$];

    diff_freq_serial_in #(
        .DATA_BIT    (16),
        .LOW_FREQ    (8'(LOW)),
        .HIGH_FREQ   (8'(HIGH)),
        .START_DELAY (SD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_serial    (i_serial),
        .i_start     (i_start),
        .i_stop      (i_stop),
        .i_sel_freq  (i_sel_freq),
        .o_data      (o_data),
        .o_done_tick (o_done_tick),
        .o_err       (o_err),
        .o_busy      (o_busy),
        .o_state     (o_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Edge j of a frame is the j-th rising edge after the one that accepts i_start.
    task automatic run_frame(input string tag, input logic [15:0] data, input logic [15:0] sel,
                             input int g_bit, input int g_cnt, input int abort_bit,
                             input int rst_bit, input int dup_j);
        int p[16];
        int e[17];
        int total, abort_j, rst_j, ticks, tick_j, k, ones, cn;
        int pos[3];
        logic [15:0] exp_data;
        logic        exp_err;
        logic        v;
        bit          interrupted;

        e[0] = SD;
        for (int i = 0; i < 16; i++) begin
            p[i]     = sel[i] ? HIGH : LOW;
            e[i + 1] = e[i] + p[i];
        end
        total = e[16];

        exp_data = '0;
        exp_err  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pos[0] = p[i] / 4;
            pos[1] = p[i] / 2;
            pos[2] = p[i] / 4 + p[i] / 2;
            ones = 0;
            for (int s = 0; s < 3; s++) begin
                v = data[i] ^ ((i == g_bit) && (pos[s] == g_cnt));
                if (v) ones++;
            end
            exp_data[i] = (ones >= 2);
            if (ones == 1 || ones == 2) exp_err = 1'b1;
        end

        abort_j = (abort_bit >= 0) ? e[abort_bit] + 3 : -1;
        rst_j   = (rst_bit >= 0) ? e[rst_bit] + 3 : -1;
        if (abort_j < 0 && rst_j < 0) exp_q.push_back({exp_err, exp_data});

        ticks = 0;
        tick_j = -1;
        interrupted = 1'b0;
        for (int j = 0; j <= total + 3; j++) begin
            @(negedge clk);
            if (j > 0) begin
                if (o_done_tick) begin
                    logic [16:0] ent;
                    ticks++;
                    tick_j = j;
                    if (exp_q.size() == 0) begin
                        check({tag, "_spurious_tick"}, 32'd1, 32'd0);
                    end else begin
                        ent = exp_q.pop_front();
                        check({tag, "_data"}, 32'(o_data), 32'(ent[15:0]));
                        check({tag, "_err"}, 32'(o_err), 32'(ent[16]));
                    end
                end
                if (j == 1) begin
                    check({tag, "_busy_start"}, 32'(o_busy), 32'd1);
                    check({tag, "_data_hold"}, 32'(o_data), 32'(prev_data));
                end
                if (j == abort_j + 1) begin
                    check({tag, "_abort_busy"}, 32'(o_busy), 32'd0);
                    check({tag, "_abort_tick"}, 32'(ticks), 32'd0);
                    check({tag, "_abort_data"}, 32'(o_data), 32'(prev_data));
                    check({tag, "_abort_err"}, 32'(o_err), 32'(prev_err));
                    interrupted = 1'b1;
                    break;
                end
            end
            if (j == rst_j) begin
                rst_n   = 1'b0;
                i_start = 1'b0;
                i_stop  = 1'b0;
                #1;
                check({tag, "_rst_data"}, 32'(o_data), 32'd0);
                check({tag, "_rst_err"}, 32'(o_err), 32'd0);
                check({tag, "_rst_busy"}, 32'(o_busy), 32'd0);
                check({tag, "_rst_tick"}, 32'(o_done_tick), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                prev_data = '0;
                prev_err  = 1'b0;
                interrupted = 1'b1;
                break;
            end
            i_start = (j == 0) || (j == dup_j);
            i_stop  = (j == abort_j);
            // The value sampled at edge j reaches the sampler in cycle j+1.
            k = -1;
            for (int i = 0; i < 16; i++)
                if (j + 1 >= e[i] && j + 1 < e[i + 1]) k = i;
            if (k < 0) begin
                i_serial = 1'b1;
            end else begin
                cn = j + 1 - e[k];
                i_serial = data[k] ^ ((k == g_bit) && (cn == g_cnt));
            end
            k = -1;
            for (int i = 0; i < 16; i++)
                if (j >= e[i] && j < e[i + 1]) k = i;
            i_sel_freq = (j < e[0]) ? sel[0] : ((k < 0) ? 1'b0 : sel[k]);
        end
        i_start = 1'b0;
        i_stop  = 1'b0;
        if (!interrupted) begin
            check({tag, "_tick_count"}, 32'(ticks), 32'd1);
            check({tag, "_tick_time"}, 32'(tick_j), 32'(total + 1));
            check({tag, "_busy_end"}, 32'(o_busy), 32'd0);
            prev_data = exp_data;
            prev_err  = exp_err;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_data", 32'(o_data), 32'd0);
        check("reset_err", 32'(o_err), 32'd0);
        check("reset_busy", 32'(o_busy), 32'd0);
        check("reset_tick", 32'(o_done_tick), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_frame("loopback", 16'hA5C3, 16'h0000, -1, -1, -1, -1, -1);
        run_frame("mixed", 16'h0001, 16'h5555, -1, -1, -1, -1, -1);
        run_frame("glitch", 16'h3C5A, 16'h0000, 5, LOW / 4, -1, -1, -1);
        run_frame("abort", 16'h1234, 16'h0F0F, -1, -1, 7, -1, -1);
        run_frame("after_abort", 16'hBEEF, 16'hFFFF, -1, -1, -1, -1, -1);
        run_frame("dup_start", 16'h8001, 16'h00FF, -1, -1, -1, -1, 100);

        @(negedge clk);
        i_start = 1'b1;
        i_stop  = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_stop  = 1'b0;
        check("start_stop_idle_busy", 32'(o_busy), 32'd0);
        @(negedge clk);
        check("start_stop_idle_tick", 32'(o_done_tick), 32'd0);

        run_frame("reset_mid", 16'h5A5A, 16'h0000, -1, -1, -1, 9, -1);
        run_frame("ffff", 16'hFFFF, 16'h0000, -1, -1, -1, -1, -1);

        for (int n = 0; n < 8; n++) begin
            logic [15:0] d, s;
            int gb;
            d  = 16'($urandom);
            s  = 16'($urandom);
            gb = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1;
            run_frame("random", d, s, gb, int'($urandom_range(0, HIGH - 1)), -1, -1, -1);
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
